// File: rtl/msk_tx_framer.sv
// msk_tx_framer: buffers host payload bytes and wraps each complete frame as
// preamble, sync word and payload, one byte per modulator byte period.
// Ports:
//   G_CLK_TX, reset            transmit clock, async active-low reset
//   tx_data/tx_valid/tx_last   host payload beat, tx_ready = FIFO not full
//   mod_data                   byte presented to the modulator
//   mod_enable, mod_restart_n  modulator enable and per-byte restart pulse
//   busy, frame_done           frame in progress, end-of-frame pulse
module msk_tx_framer #(
  parameter int                    DATA_WIDTH      = 8,
  parameter int                    FIFO_DEPTH      = 16,
  parameter int                    SAMPLES_PER_BIT = 32,
  parameter int                    PREAMBLE_LEN    = 2,
  parameter logic [DATA_WIDTH-1:0] PREAMBLE_BYTE   = 8'h55,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE       = 8'hD3
) (
  input  logic                  G_CLK_TX,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  input  logic                  tx_last,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] mod_data,
  output logic                  mod_enable,
  output logic                  mod_restart_n,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int OW       = $clog2(FIFO_DEPTH + 1);
  localparam int SEND_LEN = 8 * SAMPLES_PER_BIT;
  localparam int CW       = $clog2(SEND_LEN + 1);
  localparam int PW       = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;

  localparam logic [OW-1:0] FULL     = OW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(SEND_LEN);
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_SYNC,
    S_DATA
  } state_t;

  logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic [OW-1:0]         frames_q, frames_d;
  logic                  push, pop;
  logic                  fr_inc, fr_dec;
  logic [DATA_WIDTH:0]   rd_entry;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [PW-1:0]         pre_q;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] slot_byte;
  logic [DATA_WIDTH-1:0] mod_data_q;
  logic                  mod_enable_q;
  logic                  mod_restart_n_q;
  logic                  busy_q;
  logic                  frame_done_q;

  assign tx_ready = (occ_q != FULL);
  assign push     = tx_valid && tx_ready;
  // Payload is popped only in the LOAD cycle of a DATA slot.
  assign pop      = (state_q == S_DATA) && (cnt_q == '0);
  assign rd_entry = mem_q[rd_ptr_q];
  assign fr_inc   = push && tx_last;
  assign fr_dec   = pop && rd_entry[DATA_WIDTH];

  assign mod_data      = mod_data_q;
  assign mod_enable    = mod_enable_q;
  assign mod_restart_n = mod_restart_n_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;

  always_ff @(posedge G_CLK_TX) begin
    if (push) mem_q[wr_ptr_q] <= {tx_last, tx_data};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
    unique case ({fr_inc, fr_dec})
      2'b10:   frames_d = frames_q + OW'(1);
      2'b01:   frames_d = frames_q - OW'(1);
      default: frames_d = frames_q;
    endcase
  end

  always_ff @(posedge G_CLK_TX or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      frames_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      frames_q <= frames_d;
    end
  end

  always_comb begin
    slot_byte = rd_entry[DATA_WIDTH-1:0];
    unique case (state_q)
      S_PRE:   slot_byte = PREAMBLE_BYTE;
      S_SYNC:  slot_byte = SYNC_BYTE;
      default: slot_byte = rd_entry[DATA_WIDTH-1:0];
    endcase
  end

  // cnt_q == 0 is the LOAD cycle of a slot, 1..SEND_LEN are SEND cycles.
  always_ff @(posedge G_CLK_TX or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      pre_q           <= '0;
      last_q          <= 1'b0;
      mod_data_q      <= '0;
      mod_enable_q    <= 1'b0;
      mod_restart_n_q <= 1'b1;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        busy_q          <= 1'b0;
        mod_enable_q    <= 1'b0;
        mod_restart_n_q <= 1'b1;
        cnt_q           <= '0;
        pre_q           <= '0;
        // Start only once a whole frame sits in the FIFO.
        if (frames_q != '0) state_q <= S_PRE;
      end else if (cnt_q == '0) begin
        busy_q          <= 1'b1;
        mod_data_q      <= slot_byte;
        mod_restart_n_q <= 1'b0;
        mod_enable_q    <= 1'b0;
        cnt_q           <= CW'(1);
        if (state_q == S_DATA) last_q <= rd_entry[DATA_WIDTH];
      end else begin
        busy_q          <= 1'b1;
        mod_restart_n_q <= 1'b1;
        mod_enable_q    <= 1'b1;
        if (cnt_q == LAST_CNT) begin
          cnt_q <= '0;
          unique case (state_q)
            S_PRE: begin
              if (pre_q == PRE_LAST) begin
                pre_q   <= '0;
                state_q <= S_SYNC;
              end else begin
                pre_q <= pre_q + PW'(1);
              end
            end
            S_SYNC: state_q <= S_DATA;
            S_DATA: begin
              if (last_q) begin
                frame_done_q <= 1'b1;
                state_q      <= S_IDLE;
              end
            end
            default: state_q <= S_IDLE;
          endcase
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_msk_tx_framer.sv
// tb_msk_tx_framer: directed stimulus for msk_tx_framer, checked every cycle
// against a frame-timeline model plus literal timing/data expectations.
module tb_msk_tx_framer;

  localparam int DEPTH = 16;
  localparam int SPB   = 32;
  localparam int PRE   = 2;
  localparam int SLOT  = 1 + 8 * SPB;

  logic       G_CLK_TX;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic [7:0] mod_data;
  logic       mod_enable;
  logic       mod_restart_n;
  logic       busy;
  logic       frame_done;

  msk_tx_framer #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(DEPTH),
    .SAMPLES_PER_BIT(SPB),
    .PREAMBLE_LEN(PRE),
    .PREAMBLE_BYTE(8'h55),
    .SYNC_BYTE(8'hD3)
  ) dut (
    .G_CLK_TX(G_CLK_TX),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_last(tx_last),
    .tx_ready(tx_ready),
    .mod_data(mod_data),
    .mod_enable(mod_enable),
    .mod_restart_n(mod_restart_n),
    .busy(busy),
    .frame_done(frame_done)
  );

  initial G_CLK_TX = 1'b0;
  always #5 G_CLK_TX = ~G_CLK_TX;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge G_CLK_TX);
    cyc++;
  end

  // Model: a frame occupies (PRE + 1 + payload) slots of SLOT cycles,
  // counted from its first LOAD; one idle check precedes each start.
  typedef struct packed {
    logic       l;
    logic [7:0] d;
  } ent_t;

  ent_t       mq[$];
  int         mfr;
  int         moff;
  int         mtot;
  bit         marm;
  logic [7:0] e_data;
  logic       e_en, e_rn, e_busy, e_done;

  initial begin
    int   fpre, slot, pos, n;
    bit   acc, idle_edge, found;
    ent_t e;
    forever begin
      @(posedge G_CLK_TX or negedge reset);
      if (!reset) begin
        mq.delete();
        mfr = 0; moff = -1; mtot = 0; marm = 0;
        e_data = 8'h00; e_en = 0; e_rn = 1; e_busy = 0; e_done = 0;
      end else begin
        fpre = mfr;
        acc = tx_valid && (mq.size() < DEPTH);
        idle_edge = 0;
        if (moff >= 0) begin
          moff++;
          if (moff == mtot) begin
            moff = -1;
            idle_edge = 1;
          end
        end else if (marm) begin
          marm = 0;
          moff = 0;
          n = 0;
          found = 0;
          for (int i = 0; i < mq.size() && !found; i++) begin
            n++;
            if (mq[i].l) found = 1;
          end
          mtot = (PRE + 1 + n) * SLOT;
        end else begin
          idle_edge = 1;
        end
        if (idle_edge && fpre > 0) marm = 1;
        if (moff >= 0) begin
          slot = moff / SLOT;
          pos  = moff % SLOT;
          if (pos == 0) begin
            if (slot < PRE) e_data = 8'h55;
            else if (slot == PRE) e_data = 8'hD3;
            else begin
              e = mq.pop_front();
              e_data = e.d;
              if (e.l) mfr--;
            end
          end
          e_en   = (pos != 0);
          e_rn   = (pos != 0);
          e_busy = 1;
          e_done = (moff == mtot - 1);
        end else begin
          e_en = 0; e_rn = 1; e_busy = 0; e_done = 0;
        end
        if (acc) begin
          e.l = tx_last;
          e.d = tx_data;
          mq.push_back(e);
          if (tx_last) mfr++;
        end
      end
    end
  end

  int   load_cyc[$];
  int   load_dat[$];
  int   load_rdy[$];
  int   done_cyc[$];
  int   fall_cyc[$];
  bit   en_seen;
  logic prev_busy = 1'b0;

  initial forever begin
    logic [12:0] act_v, exp_v;
    @(negedge G_CLK_TX);
    if (reset) begin
      if (!mod_restart_n) begin
        load_cyc.push_back(cyc);
        load_dat.push_back(int'(mod_data));
        load_rdy.push_back(int'(tx_ready));
      end
      if (frame_done) done_cyc.push_back(cyc);
      if (prev_busy && !busy) fall_cyc.push_back(cyc);
      if (mod_enable) en_seen = 1;
    end
    prev_busy = busy;
    if (chk_en) begin
      act_v = {mod_data, mod_enable, mod_restart_n, busy, frame_done, tx_ready};
      exp_v = {e_data, e_en, e_rn, e_busy, e_done, mq.size() < DEPTH};
      chk("cycle", int'(act_v), int'(exp_v));
    end
  end

  function automatic int lc(input int i);
    return (i < load_cyc.size()) ? load_cyc[i] : -1;
  endfunction

  function automatic int ld(input int i);
    return (i < load_dat.size()) ? load_dat[i] : -1;
  endfunction

  function automatic int dc(input int i);
    return (i < done_cyc.size()) ? done_cyc[i] : -1;
  endfunction

  function automatic int fc(input int i);
    return (i < fall_cyc.size()) ? fall_cyc[i] : -1;
  endfunction

  task automatic clear_logs();
    load_cyc.delete();
    load_dat.delete();
    load_rdy.delete();
    done_cyc.delete();
    fall_cyc.delete();
    en_seen = 0;
  endtask

  task automatic do_reset();
    @(negedge G_CLK_TX);
    #2 reset = 1'b0;
    repeat (2) @(negedge G_CLK_TX);
    reset = 1'b1;
    clear_logs();
  endtask

  task automatic send(input logic [7:0] d, input logic l, output int acc);
    int n;
    acc = -1;
    n = 0;
    @(negedge G_CLK_TX);
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = l;
    while (acc < 0 && n < 200) begin
      if (tx_ready) acc = cyc + 1;
      @(negedge G_CLK_TX);
      n++;
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    chk("send_accepted", int'(acc >= 0), 1);
  endtask

  task automatic wait_loads(input int n, input int budget);
    int k;
    k = 0;
    while (load_cyc.size() < n && k < budget) begin
      @(negedge G_CLK_TX);
      k++;
    end
    chk("wait_loads", int'(load_cyc.size() >= n), 1);
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_cyc.size() < n && k < budget) begin
      @(negedge G_CLK_TX);
      k++;
    end
    repeat (3) @(negedge G_CLK_TX);
    chk("wait_done", int'(done_cyc.size() >= n), 1);
  endtask

  initial begin
    int acc, t0;
    int exp1[4];
    int exp2[6];
    int exp3[9];
    exp1 = '{8'h55, 8'h55, 8'hD3, 8'hA7};
    exp2 = '{8'h55, 8'h55, 8'hD3, 8'h01, 8'h02, 8'h03};
    exp3 = '{8'h55, 8'h55, 8'hD3, 8'h11, 8'h55, 8'h55, 8'hD3, 8'h22, 8'h33};

    reset    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    repeat (3) @(negedge G_CLK_TX);
    chk("rst_data", int'(mod_data), 0);
    chk("rst_en", int'(mod_enable), 0);
    chk("rst_restart_n", int'(mod_restart_n), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_ready", int'(tx_ready), 1);
    chk_en = 1;
    reset = 1'b1;
    clear_logs();
    repeat (100) @(negedge G_CLK_TX);
    chk("idle_busy", int'(busy), 0);
    chk("idle_en_seen", int'(en_seen), 0);

    clear_logs();
    send(8'hA7, 1'b1, acc);
    wait_loads(4, 2000);
    wait_done(1, 2000);
    t0 = acc + 2;
    for (int i = 0; i < 4; i++) begin
      chk("single_load_cyc", lc(i), t0 + SLOT * i);
      chk("single_load_dat", ld(i), exp1[i]);
    end
    chk("single_done_cyc", dc(0), t0 + 1027);
    chk("single_busy_fall", fc(0), t0 + 1028);

    clear_logs();
    send(8'h01, 1'b0, acc);
    send(8'h02, 1'b0, acc);
    repeat (500) @(negedge G_CLK_TX);
    chk("partial_busy", int'(busy), 0);
    chk("partial_no_load", load_cyc.size(), 0);
    send(8'h03, 1'b1, acc);
    wait_loads(6, 3000);
    wait_done(1, 3000);
    for (int i = 0; i < 6; i++) chk("partial_dat", ld(i), exp2[i]);
    chk("partial_start", lc(0), acc + 2);

    do_reset();
    for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b0, acc);
    chk("full_ready", int'(tx_ready), 0);
    @(negedge G_CLK_TX);
    tx_valid = 1'b1;
    tx_data  = 8'hEE;
    tx_last  = 1'b1;
    repeat (20) @(negedge G_CLK_TX);
    chk("full_held_ready", int'(tx_ready), 0);
    chk("full_held_busy", int'(busy), 0);
    tx_valid = 1'b0;
    tx_last  = 1'b0;

    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) send(8'(8'h80 + i), 1'b0, acc);
    send(8'h8F, 1'b1, acc);
    chk("full2_ready", int'(tx_ready), 0);
    wait_loads(4, 2000);
    chk("full2_rdy_sync", (load_rdy.size() > 2) ? load_rdy[2] : -1, 0);
    chk("full2_rdy_pop", (load_rdy.size() > 3) ? load_rdy[3] : -1, 1);
    chk("full2_first_dat", ld(3), 8'h80);
    wait_done(1, 6000);
    chk("full2_done_cyc", dc(0), lc(0) + 19 * SLOT - 1);

    do_reset();
    send(8'h11, 1'b1, acc);
    t0 = acc + 2;
    send(8'h22, 1'b0, acc);
    send(8'h33, 1'b1, acc);
    wait_done(2, 5000);
    for (int i = 0; i < 9; i++) chk("b2b_dat", ld(i), exp3[i]);
    chk("b2b_first_load", lc(0), t0);
    chk("b2b_second_load", lc(4), t0 + 1029);
    chk("b2b_done0", dc(0), t0 + 1027);
    chk("b2b_gap", fc(0), t0 + 1028);
    chk("b2b_done_count", done_cyc.size(), 2);

    clear_logs();
    send(8'h5A, 1'b1, acc);
    wait_loads(3, 1500);
    repeat (10) @(negedge G_CLK_TX);
    chk("mid_pre_busy", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_data", int'(mod_data), 0);
    chk("mid_rst_en", int'(mod_enable), 0);
    chk("mid_rst_restart_n", int'(mod_restart_n), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(tx_ready), 1);
    repeat (2) @(negedge G_CLK_TX);
    reset = 1'b1;
    clear_logs();
    repeat (50) @(negedge G_CLK_TX);
    chk("post_rst_loads", load_cyc.size(), 0);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_en_seen", int'(en_seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
